// File: rtl/wb_qcw_shot_master.sv
`timescale 1ns/1ps
// Wishbone initiator: one trigger runs a full QCW shot (three config writes, START, STATUS polling).
// Latency: one idle cycle before every access, then stb is held until ack or ACK_TIMEOUT cycles.
// Backpressure: the slave stalls the shot by withholding ack; shot_trig is dropped while busy.
module wb_qcw_shot_master #(
  parameter logic [31:0] SLAVE_BASE    = 32'h1000000,
  parameter int          ACK_TIMEOUT   = 64,
  parameter int          POLL_INTERVAL = 256,
  parameter int          MAX_POLLS     = 4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        shot_trig,
  input  logic [7:0]  cfg_phase_start,
  input  logic [15:0] cfg_phase_step,
  input  logic [15:0] cfg_cycle_limit,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy,
  output logic        shot_done,
  output logic        res_done,
  output logic        res_fault,
  output logic        res_timeout,
  output logic        res_bus_err
);

  localparam logic [15:0] ACK_LIM  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] IVL_LIM  = 16'(POLL_INTERVAL - 1);
  localparam logic [12:0] POLL_LIM = 13'(MAX_POLLS);

  typedef enum logic [2:0] {
    IDLE, WR_PSTART, WR_PSTEP, WR_CLIM, WR_START, POLL_WAIT, RD_STATUS, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  phase_start_q, phase_start_d;
  logic [15:0] phase_step_q, phase_step_d;
  logic [15:0] cycle_limit_q, cycle_limit_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic [15:0] ivl_cnt_q, ivl_cnt_d;
  logic [12:0] poll_cnt_q, poll_cnt_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
  logic        busy_q, busy_d, shot_done_q, shot_done_d;
  logic        res_done_q, res_done_d, res_fault_q, res_fault_d;
  logic        res_timeout_q, res_timeout_d, res_bus_err_q, res_bus_err_d;

  logic [31:0] acc_adr, acc_dat;
  logic        acc_we, is_acc;
  state_t      acc_next;
  logic [12:0] poll_inc;
  logic        unused_dat;

  assign unused_dat = ^wb_dat_i[31:2];
  assign poll_inc   = poll_cnt_q + 13'd1;

  // Address, data and successor state of the access owned by the current state.
  always_comb begin
    acc_adr  = SLAVE_BASE;
    acc_dat  = 32'h0;
    acc_we   = 1'b1;
    acc_next = IDLE;
    is_acc   = 1'b1;
    case (state_q)
      WR_PSTART: begin
        acc_adr  = SLAVE_BASE + 32'h00;
        acc_dat  = {24'b0, phase_start_q};
        acc_next = WR_PSTEP;
      end
      WR_PSTEP: begin
        acc_adr  = SLAVE_BASE + 32'h04;
        acc_dat  = {16'b0, phase_step_q};
        acc_next = WR_CLIM;
      end
      WR_CLIM: begin
        acc_adr  = SLAVE_BASE + 32'h08;
        acc_dat  = {16'b0, cycle_limit_q};
        acc_next = WR_START;
      end
      WR_START: begin
        acc_adr  = SLAVE_BASE + 32'h0C;
        acc_dat  = 32'h1;
        acc_next = POLL_WAIT;
      end
      RD_STATUS: begin
        acc_adr  = SLAVE_BASE + 32'h10;
        acc_we   = 1'b0;
        acc_next = FINISH;
      end
      default: is_acc = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    phase_start_d = phase_start_q;
    phase_step_d  = phase_step_q;
    cycle_limit_d = cycle_limit_q;
    ack_cnt_d     = ack_cnt_q;
    ivl_cnt_d     = ivl_cnt_q;
    poll_cnt_d    = poll_cnt_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    sel_d         = sel_q;
    we_d          = we_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    busy_d        = busy_q;
    shot_done_d   = 1'b0;
    res_done_d    = res_done_q;
    res_fault_d   = res_fault_q;
    res_timeout_d = res_timeout_q;
    res_bus_err_d = res_bus_err_q;

    if (is_acc) begin
      if (!stb_q) begin
        // Launch only once a lingering ack from the previous access has gone away.
        if (!wb_ack_i) begin
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          sel_d     = 4'hF;
          we_d      = acc_we;
          dat_d     = acc_we ? acc_dat : 32'h0;
          adr_d     = acc_adr;
          ack_cnt_d = 16'd0;
        end else if (ack_cnt_q == ACK_LIM) begin
          res_bus_err_d = 1'b1;
          state_d       = FINISH;
        end else begin
          ack_cnt_d = ack_cnt_q + 16'd1;
        end
      end else if (wb_ack_i || ack_cnt_q == ACK_LIM) begin
        cyc_d     = 1'b0;
        stb_d     = 1'b0;
        sel_d     = 4'h0;
        we_d      = 1'b0;
        dat_d     = 32'h0;
        ack_cnt_d = 16'd0;
        ivl_cnt_d = 16'd0;
        if (!wb_ack_i) begin
          res_bus_err_d = 1'b1;
          state_d       = FINISH;
        end else if (state_q == RD_STATUS) begin
          poll_cnt_d = poll_inc;
          if (wb_dat_i[1]) begin
            res_fault_d = 1'b1;
            res_done_d  = wb_dat_i[0];
            state_d     = FINISH;
          end else if (wb_dat_i[0]) begin
            res_done_d = 1'b1;
            state_d    = FINISH;
          end else if (poll_inc == POLL_LIM) begin
            res_timeout_d = 1'b1;
            state_d       = FINISH;
          end else begin
            state_d = POLL_WAIT;
          end
        end else begin
          state_d = acc_next;
        end
      end else begin
        ack_cnt_d = ack_cnt_q + 16'd1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (shot_trig) begin
            phase_start_d = cfg_phase_start;
            phase_step_d  = cfg_phase_step;
            cycle_limit_d = cfg_cycle_limit;
            res_done_d    = 1'b0;
            res_fault_d   = 1'b0;
            res_timeout_d = 1'b0;
            res_bus_err_d = 1'b0;
            poll_cnt_d    = 13'd0;
            ack_cnt_d     = 16'd0;
            busy_d        = 1'b1;
            state_d       = WR_PSTART;
          end
        end
        POLL_WAIT: begin
          if (ivl_cnt_q == IVL_LIM) begin
            ack_cnt_d = 16'd0;
            state_d   = RD_STATUS;
          end else begin
            ivl_cnt_d = ivl_cnt_q + 16'd1;
          end
        end
        FINISH: begin
          shot_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      phase_start_q <= 8'h0;
      phase_step_q  <= 16'h0;
      cycle_limit_q <= 16'h0;
      ack_cnt_q     <= 16'h0;
      ivl_cnt_q     <= 16'h0;
      poll_cnt_q    <= 13'h0;
      adr_q         <= 32'h0;
      dat_q         <= 32'h0;
      sel_q         <= 4'h0;
      we_q          <= 1'b0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      busy_q        <= 1'b0;
      shot_done_q   <= 1'b0;
      res_done_q    <= 1'b0;
      res_fault_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_bus_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_start_q <= phase_start_d;
      phase_step_q  <= phase_step_d;
      cycle_limit_q <= cycle_limit_d;
      ack_cnt_q     <= ack_cnt_d;
      ivl_cnt_q     <= ivl_cnt_d;
      poll_cnt_q    <= poll_cnt_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      busy_q        <= busy_d;
      shot_done_q   <= shot_done_d;
      res_done_q    <= res_done_d;
      res_fault_q   <= res_fault_d;
      res_timeout_q <= res_timeout_d;
      res_bus_err_q <= res_bus_err_d;
    end
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign busy        = busy_q;
  assign shot_done   = shot_done_q;
  assign res_done    = res_done_q;
  assign res_fault   = res_fault_q;
  assign res_timeout = res_timeout_q;
  assign res_bus_err = res_bus_err_q;

endmodule
